// File: rtl/seg7_scan_display.sv
// seg7_scan_display
// Latches a 32-bit print value and scans it as 8 hex digits across a
// time-multiplexed, active-low 7-segment display. While the CPU is halted,
// the decimal point of digit 0 blinks.
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking. Digit 0
// is never blanked. When the macro is undefined, all 8 digits are always
// driven.
module seg7_scan_display #(
    parameter int CLK_DIV     = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        load,
    input  logic [31:0] data,
    input  logic        halt,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [31:0]   shadow;
    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          tick;

    logic [3:0]    nibble;
    logic          blank;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    // Shadow register: load only touches the displayed value, never the scan.
    always_ff @(posedge CLK) begin
        if (CLR)
            shadow <= '0;
        else if (load)
            shadow <= data;
    end

    // Refresh divider and scan index; idx advances once per digit slot.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick)
                idx <= idx + 3'd1;
        end
    end

    // Halt blink phase; held cleared whenever the CPU is running.
    always_ff @(posedge CLK) begin
        if (CLR || !halt) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Next digit drive from the current scan slot and shadow value.
    always_comb begin
        nibble = shadow[{idx, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        blank  = (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
`else
        blank  = 1'b0;
`endif
        an_next  = blank ? 8'hFF : ~(8'b1 << idx);
        seg_next = blank ? 7'h7F : hex7(nibble);
        dp_next  = ~(halt & blink_ph & (idx == 3'd0));
    end

    // Registered pin drive; no input reaches a pin combinationally.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            AN  <= 8'hFF;
            SEG <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= an_next;
            SEG <= seg_next;
            DP  <= dp_next;
        end
    end

endmodule
